// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Fans one asynchronous board reset out to NUM_CH reset domains in the
//   i_aclk domain. Every channel asserts asynchronously. Release is
//   synchronous: the board reset is first synchronized, then a hold period
//   runs, and then the channels release one at a time in ascending order,
//   STAGGER_CYCLES apart.
//
//   Optional feature: when RST_SEQ_SW_RESET_EN is defined, i_sw_reset
//   synchronously re-enters the hold period. When it is not defined,
//   i_sw_reset has no effect.
//
// Ports
//   i_aclk      : system clock
//   i_reset     : asynchronous active-low board reset
//   i_sw_reset  : synchronous active-high software reset request
//   o_areset_n  : per-channel active-low reset, bit 0 releases first
//   o_busy      : high while any channel is held in reset
//   o_done      : high once every channel has been released
module reset_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic              i_aclk,
    input  logic              i_reset,
    input  logic              i_sw_reset,
    output logic [NUM_CH-1:0] o_areset_n,
    output logic              o_busy,
    output logic              o_done
);

    localparam int HCW  = $clog2(HOLD_CYCLES + 1);
    localparam int SCW  = (STAGGER_CYCLES == 0) ? 1 : $clog2(STAGGER_CYCLES + 1);
    localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [SCW-1:0]  STAG_LAST = (STAGGER_CYCLES == 0) ? '0 : SCW'(STAGGER_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NUM_CH - 1);

    typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

    state_t              state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [HCW-1:0]      hold_cnt_q;
    logic [SCW-1:0]      stag_cnt_q;
    logic [IDXW-1:0]     idx_q;
    logic [NUM_CH-1:0]   rst_n_q;
    logic                busy_q;
    logic                done_q;
    logic                rst_sync_n;
    logic                sw_req;

`ifdef RST_SEQ_SW_RESET_EN
    assign sw_req = i_sw_reset;
`else
    // Request tied off; the port is kept so the interface does not change.
    logic unused_sw;
    assign unused_sw = i_sw_reset;
    assign sw_req    = 1'b0;
`endif

    // Release synchronizer. Any low pulse on i_reset clears every stage,
    // so even a sub-cycle glitch restarts the whole sequence.
    always_ff @(posedge i_aclk or negedge i_reset) begin
        if (!i_reset) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_aclk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (sw_req) begin
                        // Request during hold restarts the hold period.
                        hold_cnt_q <= '0;
                    end else if (rst_sync_n) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            if (STAGGER_CYCLES == 0 || NUM_CH == 1) begin
                                rst_n_q <= '1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_RUN;
                            end else begin
                                rst_n_q    <= NUM_CH'(1);
                                idx_q      <= IDXW'(1);
                                stag_cnt_q <= '0;
                                state_q    <= S_RELEASE;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + HCW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    if (sw_req) begin
                        rst_n_q    <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        hold_cnt_q <= '0;
                        stag_cnt_q <= '0;
                        idx_q      <= '0;
                        state_q    <= S_HOLD;
                    end else if (stag_cnt_q == STAG_LAST) begin
                        rst_n_q    <= rst_n_q | (NUM_CH'(1) << idx_q);
                        stag_cnt_q <= '0;
                        idx_q      <= idx_q + IDXW'(1);
                        // Last channel released: flags flip on the same edge.
                        if (idx_q == IDX_LAST) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end else begin
                        stag_cnt_q <= stag_cnt_q + SCW'(1);
                    end
                end
                S_RUN: begin
                    if (sw_req) begin
                        rst_n_q    <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        hold_cnt_q <= '0;
                        stag_cnt_q <= '0;
                        idx_q      <= '0;
                        state_q    <= S_HOLD;
                    end
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign o_areset_n = rst_n_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Three sequencers share the clock and board reset:
//     A: defaults (4 ch, hold 16, stagger 4)
//     B: 4 ch, hold 1, stagger 0 (all channels release together)
//     C: 1 ch, hold 3
//   Expected outputs come from a release-threshold model. They are queued
//   at each rising edge and compared on the following falling edge.
module tb_reset_sequencer;

    localparam int SYNC = 2;
`ifdef RST_SEQ_SW_RESET_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sw    = 1'b0;
    logic [3:0] a_rst, b_rst;
    logic [0:0] c_rst;
    logic       a_busy, a_done, b_busy, b_done, c_busy, c_done;

    always #5 clk = ~clk;

    reset_sequencer u_a (
        .i_aclk(clk), .i_reset(rst_n), .i_sw_reset(sw),
        .o_areset_n(a_rst), .o_busy(a_busy), .o_done(a_done)
    );

    reset_sequencer #(.NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGGER_CYCLES(0)) u_b (
        .i_aclk(clk), .i_reset(rst_n), .i_sw_reset(sw),
        .o_areset_n(b_rst), .o_busy(b_busy), .o_done(b_done)
    );

    reset_sequencer #(.NUM_CH(1), .SYNC_STAGES(2), .HOLD_CYCLES(3), .STAGGER_CYCLES(4)) u_c (
        .i_aclk(clk), .i_reset(rst_n), .i_sw_reset(sw),
        .o_areset_n(c_rst), .o_busy(c_busy), .o_done(c_done)
    );

    typedef struct {
        logic [5:0] a;   // {rst[3:0], done, busy}
        logic [5:0] b;
        logic [2:0] c;
    } exp_t;

    typedef struct {
        int         edge_n;
        logic [3:0] rst;
    } vec_t;

    exp_t       sbq[$];
    vec_t       tbl[9];
    logic [3:0] a_obs [0:40];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Channel k is released once n reaches off + hold + k*stagger.
    function automatic logic [3:0] model(input int n, input int off, input int h,
                                         input int st, input int nch);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < nch; k++)
            if (n >= off + h + k * st) r[k] = 1'b1;
        return r;
    endfunction

    function automatic exp_t mk_exp(input int n, input int off, input bit ones);
        exp_t       e;
        logic [3:0] ra, rb, rc;
        ra = ones ? 4'hF : model(n, off, 16, 4, 4);
        rb = ones ? 4'hF : model(n, off, 1, 0, 4);
        rc = ones ? 4'h1 : model(n, off, 3, 4, 1);
        e.a = {ra, &ra, ~&ra};
        e.b = {rb, &rb, ~&rb};
        e.c = {rc[0], rc[0], ~rc[0]};
        return e;
    endfunction

    // Runs edges n0..n1. For software-reset runs, nhi > 0 holds sw high
    // for the first nhi edges, and off = nhi-1 places the release relative
    // to the last edge that samples sw high.
    task automatic run_seq(input int n0, input int n1, input int off, input int nhi,
                           input string tag);
        exp_t e;
        bit   ones;
        ones = (nhi > 0) && !SW_EN;
        for (int n = n0; n <= n1; n++) begin
            @(posedge clk);
            sbq.push_back(mk_exp(n, off, ones));
            @(negedge clk);
            sw = (n - n0 + 1) < nhi;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s scoreboard empty at edge %0d", tag, n);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("%s A edge %0d", tag, n), {a_rst, a_done, a_busy}, e.a);
                chk($sformatf("%s B edge %0d", tag, n), {b_rst, b_done, b_busy}, e.b);
                chk($sformatf("%s C edge %0d", tag, n), {c_rst, c_done, c_busy}, e.c);
            end
            if (n >= 0 && n <= 40) a_obs[n] = a_rst;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " A"}, {a_rst, a_done, a_busy}, 6'b0000_0_1);
        chk({tag, " B"}, {b_rst, b_done, b_busy}, 6'b0000_0_1);
        chk({tag, " C"}, {c_rst, c_done, c_busy}, 3'b0_0_1);
    endtask

    initial begin
        tbl[0] = '{1,  4'b0000};
        tbl[1] = '{17, 4'b0000};
        tbl[2] = '{18, 4'b0001};
        tbl[3] = '{21, 4'b0001};
        tbl[4] = '{22, 4'b0011};
        tbl[5] = '{25, 4'b0011};
        tbl[6] = '{26, 4'b0111};
        tbl[7] = '{29, 4'b0111};
        tbl[8] = '{30, 4'b1111};

        // Power-on: reset held low for 5 cycles, then released.
        @(negedge clk);
        #1 chk_reset("por reset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        run_seq(1, 32, SYNC, 0, "por");
        foreach (tbl[i])
            chk($sformatf("por table edge %0d", tbl[i].edge_n), a_obs[tbl[i].edge_n], tbl[i].rst);

        // Mid-sequence reset: drop between edges 24 and 25 and check
        // before the next clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        run_seq(1, 24, SYNC, 0, "pre-mid");
        #2 rst_n = 1'b0;
        #1 chk_reset("mid async");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_seq(1, 32, SYNC, 0, "mid restart");

        // Glitch: 2 ns low pulse inside one cycle while in RUN.
        #1 rst_n = 1'b0;
        #1 chk_reset("glitch async");
        #1 rst_n = 1'b1;
        run_seq(1, 32, SYNC, 0, "glitch restart");

        // Software reset: single-cycle pulse in RUN.
        sw = 1'b1;
        run_seq(0, 30, 0, 1, "sw pulse");
        // Software reset held for three edges; the hold restarts each time.
        sw = 1'b1;
        run_seq(0, 32, 2, 3, "sw hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
